// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: word width, op encodings
// and default pipeline/FIFO sizing.
package dmem_responder_pkg;

  localparam int unsigned WORD       = 16;
  localparam int unsigned DefLatency = 2;
  localparam int unsigned DefDepth   = 4;

  typedef enum logic {
    OpLoad  = 1'b0,
    OpStore = 1'b1
  } op_e;

endpackage

// File: rtl/dmem_responder_resp_fifo.sv
// Response FIFO: DEPTH x WIDTH circular buffer with same-cycle push/pop and
// an occupancy count. Head data reads as zero while empty.
module resp_fifo
  import dmem_responder_pkg::*;
#(
  parameter int unsigned DEPTH = DefDepth,
  parameter int unsigned WIDTH = WORD
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_pop;

  assign empty     = (count_q == '0);
  assign full      = (count_q == CW'(DEPTH));
  assign count     = count_q;
  assign do_pop    = pop && !empty;
  assign head_data = empty ? '0 : mem_q[rd_ptr_q];

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      count_q <= count_q + CW'(push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: owns the memory array, executes stores, returns load
// data through a fixed-latency pipeline and a response FIFO, throttled by credits.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned AW      = 16,
  parameter int unsigned LATENCY = DefLatency,
  parameter int unsigned DEPTH   = DefDepth
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  input  logic            req_we,
  input  logic [15:0]     req_addr,
  input  logic [WORD-1:0] req_wdata,
  output logic            req_ready,
  output logic            rsp_valid,
  output logic [WORD-1:0] rsp_data,
  input  logic            rsp_ready,
  output logic            busy
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WORD-1:0]    mem [2**AW];
  logic [AW-1:0]      addr;
  logic               is_store;
  logic               store_acc;
  logic               load_acc;
  logic               pop;
  logic               push;
  logic [CW-1:0]      out_q, out_d;
  logic [LATENCY-1:0] pipe_vld_q;
  logic [WORD-1:0]    pipe_data_q [LATENCY];
  logic [CW-1:0]      fifo_count;
  logic               fifo_empty;
  logic               fifo_full;

  assign addr      = req_addr[AW-1:0];
  assign is_store  = (op_e'(req_we) == OpStore);
  assign req_ready = (out_q < CW'(DEPTH));
  assign store_acc = req_valid && req_ready && is_store;
  assign load_acc  = req_valid && req_ready && !is_store;
  assign rsp_valid = !fifo_empty;
  assign pop       = rsp_valid && rsp_ready;
  assign push      = pipe_vld_q[LATENCY-1];
  assign busy      = (out_q != '0);

  always_ff @(posedge clk) begin
    if (store_acc) begin
      mem[addr] <= req_wdata;
    end
  end

  // Load data is captured at accept, so later stores cannot leak into it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pipe_vld_q <= '0;
    end else begin
      pipe_vld_q[0] <= load_acc;
      for (int i = 1; i < LATENCY; i++) begin
        pipe_vld_q[i] <= pipe_vld_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (load_acc) begin
      pipe_data_q[0] <= mem[addr];
    end
    for (int i = 1; i < LATENCY; i++) begin
      pipe_data_q[i] <= pipe_data_q[i-1];
    end
  end

  always_comb begin
    out_d = out_q;
    if (load_acc && !pop) begin
      out_d = out_q + CW'(1);
    end else if (!load_acc && pop) begin
      out_d = out_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  resp_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(WORD)
  ) u_resp_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_data(pipe_data_q[LATENCY-1]),
    .pop      (pop),
    .head_data(rsp_data),
    .count    (fifo_count),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

`ifndef SYNTHESIS
  a_out_bound: assert property (@(posedge clk) disable iff (!reset) out_q <= CW'(DEPTH));
  a_no_ovf:    assert property (@(posedge clk) disable iff (!reset) !(push && fifo_full));
  a_fifo_le:   assert property (@(posedge clk) disable iff (!reset) fifo_count <= out_q);
  a_latency:   assert property (@(posedge clk) (LATENCY >= 1) && (LATENCY <= 4));
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_dmem_responder;

  localparam int unsigned AW      = 8;
  localparam int unsigned LATENCY = 2;
  localparam int unsigned DEPTH   = 4;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_we;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        req_ready;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        rsp_ready;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  dmem_responder #(
    .AW     (AW),
    .LATENCY(LATENCY),
    .DEPTH  (DEPTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_we   (req_we),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid),
    .rsp_data (rsp_data),
    .rsp_ready(rsp_ready),
    .busy     (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%b required=%b at %0t", name, act, exp, $time);
  endtask

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
  endtask

  // Reference model: loads wait in a timed queue, then sit in a FIFO queue.
  typedef struct {
    logic [15:0] data;
    int          due;
  } pend_t;

  pend_t       pipe_m[$];
  logic [15:0] fifo_m[$];
  logic [15:0] mem_m[int];
  int          tcyc = 0;
  logic [15:0] dut_log[$];

  always @(posedge clk or negedge reset) begin
    bit    rdy;
    int    a;
    pend_t p;
    if (!reset) begin
      pipe_m.delete();
      fifo_m.delete();
    end else begin
      rdy = (pipe_m.size() + fifo_m.size()) < DEPTH;
      tcyc++;
      if (fifo_m.size() > 0 && rsp_ready) void'(fifo_m.pop_front());
      while (pipe_m.size() > 0 && pipe_m[0].due == tcyc) begin
        p = pipe_m.pop_front();
        fifo_m.push_back(p.data);
      end
      if (req_valid && rdy) begin
        a = int'(req_addr) % (1 << AW);
        if (req_we) mem_m[a] = req_wdata;
        else begin
          p.data = mem_m[a];
          p.due  = tcyc + LATENCY;
          pipe_m.push_back(p);
        end
      end
    end
  end

  always @(negedge clk) begin
    int outstanding;
    outstanding = pipe_m.size() + fifo_m.size();
    check1("req_ready", req_ready, outstanding < DEPTH);
    check1("busy", busy, outstanding != 0);
    check1("rsp_valid", rsp_valid, fifo_m.size() > 0);
    if (fifo_m.size() > 0) check16("rsp_data", rsp_data, fifo_m[0]);
    if (rsp_valid && rsp_ready) dut_log.push_back(rsp_data);
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic we, input logic [15:0] addr, input logic [15:0] wdata);
    logic acc;
    acc       = 1'b0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    for (int i = 0; i < 50 && !acc; i++) begin
      acc = req_ready;
      step(1);
    end
    req_valid = 1'b0;
    if (!acc) check1("send_accept", acc, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = 1'b0;

    // Reset state
    #12;
    check1("rst_req_ready", req_ready, 1'b1);
    check1("rst_rsp_valid", rsp_valid, 1'b0);
    check1("rst_busy", busy, 1'b0);
    check16("rst_rsp_data", rsp_data, 16'h0000);
    #10 reset = 1'b1;
    step(2);

    // Store then load: exact latency and data
    rsp_ready = 1'b1;
    send(1'b1, 16'h0010, 16'h1234);
    send(1'b0, 16'h0010, 16'h0000);
    check1("lat_n0_valid", rsp_valid, 1'b0);
    step(1);
    check1("lat_n1_valid", rsp_valid, 1'b0);
    step(1);
    check1("lat_n2_valid", rsp_valid, 1'b1);
    check16("lat_n2_data", rsp_data, 16'h1234);
    step(1);
    check1("lat_busy_fall", busy, 1'b0);

    // Load captures value at accept, later store does not affect it
    dut_log.delete();
    send(1'b1, 16'h0020, 16'hAAAA);
    send(1'b0, 16'h0020, 16'h0000);
    send(1'b1, 16'h0020, 16'h5555);
    send(1'b0, 16'h0020, 16'h0000);
    step(8);
    check16("raw_count", 16'(dut_log.size()), 16'd2);
    if (dut_log.size() == 2) begin
      check16("raw_old", dut_log[0], 16'hAAAA);
      check16("raw_new", dut_log[1], 16'h5555);
    end

    // Credit exhaustion with five loads, then drain in order
    for (int i = 0; i < 5; i++) send(1'b1, 16'h0030 + 16'(i), 16'h0300 + 16'(i));
    rsp_ready = 1'b0;
    step(1);
    dut_log.delete();
    for (int i = 0; i < 4; i++) send(1'b0, 16'h0030 + 16'(i), 16'h0000);
    check1("full_ready_low", req_ready, 1'b0);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 16'h0034;
    for (int i = 0; i < 3; i++) begin
      step(1);
      check1("fifth_held", req_ready, 1'b0);
    end
    rsp_ready = 1'b1;
    step(1);
    check1("credit_freed", req_ready, 1'b1);
    step(1);
    req_valid = 1'b0;
    step(10);
    check16("drain_count", 16'(dut_log.size()), 16'd5);
    if (dut_log.size() == 5) begin
      for (int i = 0; i < 5; i++) check16("drain_order", dut_log[i], 16'h0300 + 16'(i));
    end

    // Steady stream: one load per cycle, no bubbles
    for (int i = 0; i < 16; i++) send(1'b1, 16'h0040 + 16'(i), 16'h4000 + 16'(i));
    step(1);
    dut_log.delete();
    for (int i = 0; i < 16; i++) begin
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = 16'h0040 + 16'(i);
      check1("stream_ready", req_ready, 1'b1);
      if (i >= 3) check1("stream_nobubble", rsp_valid, 1'b1);
      step(1);
    end
    req_valid = 1'b0;
    step(8);
    check16("stream_count", 16'(dut_log.size()), 16'd16);
    if (dut_log.size() == 16) begin
      check16("stream_first", dut_log[0], 16'h4000);
      check16("stream_last", dut_log[15], 16'h400F);
    end

    // Reset with loads outstanding; store on the last edge survives
    for (int i = 0; i < 3; i++) send(1'b1, 16'h0050 + 16'(i), 16'h5000 + 16'(i));
    send(1'b1, 16'h0060, 16'h0000);
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(1'b0, 16'h0050 + 16'(i), 16'h0000);
    send(1'b1, 16'h0060, 16'h7777);
    #2 reset = 1'b0;
    #1;
    check1("mid_rst_valid", rsp_valid, 1'b0);
    check1("mid_rst_busy", busy, 1'b0);
    check1("mid_rst_ready", req_ready, 1'b1);
    #10 reset = 1'b1;
    step(1);
    dut_log.delete();
    rsp_ready = 1'b1;
    step(6);
    check16("mid_rst_no_rsp", 16'(dut_log.size()), 16'd0);
    send(1'b0, 16'h0060, 16'h0000);
    step(5);
    check16("kept_store_count", 16'(dut_log.size()), 16'd1);
    if (dut_log.size() == 1) check16("kept_store", dut_log[0], 16'h7777);

    // Address wrap modulo 2^AW
    dut_log.delete();
    send(1'b1, 16'h00FF, 16'hBEEF);
    send(1'b0, 16'hFFFF, 16'h0000);
    send(1'b1, 16'h01F0, 16'h1357);
    send(1'b0, 16'h00F0, 16'h0000);
    step(6);
    check16("wrap_count", 16'(dut_log.size()), 16'd2);
    if (dut_log.size() == 2) begin
      check16("wrap_ffff", dut_log[0], 16'hBEEF);
      check16("wrap_1f0", dut_log[1], 16'h1357);
    end

    step(2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
